main_mem: RTL

Word-addressed main-memory model with a fixed, parameterised access latency. It sits directly downstream of the cache controller FSM and services that FSM's memory strobe and read/write requests on a miss or write-through. Each accepted request holds the block busy for a programmable number of cycles, performs the access, then pulses a one-cycle ready. The controller's wait counter and its `CtrSig` input are sized to this latency.

---
 rtl/main_mem.sv | 117 +++++++++++
 1 files changed

// File: rtl/main_mem.sv
`default_nettype none
// ============================================================================
//  Module   : main_mem
//  Purpose  : Word-addressed main-memory model with a fixed access latency.
//             Serves one request at a time from the cache controller: the
//             request is latched on the accept edge and held busy for a fixed
//             number of cycles. The access is then performed and MRdy pulses
//             for one cycle.
//  Ports    : clk       - clock, rising edge
//             reset     - synchronous, active-high
//             MStrobe   - request strobe (only honoured while idle)
//             MRW       - 1 = read, 0 = write (sampled with MStrobe)
//             MAddr     - word address        (sampled with MStrobe)
//             MDataIn   - write data          (sampled with MStrobe)
//             MDataOut  - read data register, updated only on read completion
//             MRdy      - one-cycle completion pulse
//             MBusy     - high while a request is in flight
//  Revision : 1.0  initial release
// ============================================================================
module main_mem #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 32,
    parameter int LATENCY = 4      // legal range 2..255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              MStrobe,
    input  logic              MRW,
    input  logic [ADDR_W-1:0] MAddr,
    input  logic [DATA_W-1:0] MDataIn,
    output logic [DATA_W-1:0] MDataOut,
    output logic              MRdy,
    output logic              MBusy
);

    localparam int         c_DEPTH    = 2 ** ADDR_W;
    // The accept edge and the access edge each account for one cycle of the
    // latency, so the counter only covers the remaining LATENCY-2 BUSY edges.
    localparam logic [7:0] c_CNT_LOAD = 8'(LATENCY - 2);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [7:0]          r_cnt;
    logic                r_rw;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W-1:0]   r_rdata;
    logic [DATA_W-1:0]   r_mem [0:c_DEPTH-1];

    logic                w_accept;
    logic                w_access;

    assign w_accept = (r_state == S_IDLE) && MStrobe;
    // Access happens on the last BUSY edge; reset on that same edge aborts it.
    assign w_access = (r_state == S_BUSY) && (r_cnt == 8'd0) && !reset;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (MStrobe)         w_state_next = S_BUSY;
            S_BUSY:  if (r_cnt == 8'd0)   w_state_next = S_DONE;
            S_DONE:                       w_state_next = S_IDLE;
            default:                      w_state_next = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // State, counter, request latches and read-data register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= 8'd0;
            r_rw    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_rw    <= MRW;
                r_addr  <= MAddr;
                r_wdata <= MDataIn;
                r_cnt   <= c_CNT_LOAD;
            end else if (r_state == S_BUSY && r_cnt != 8'd0) begin
                r_cnt   <= r_cnt - 8'd1;
            end
            if (w_access && r_rw) begin
                r_rdata <= r_mem[r_addr];
            end
        end
    end

    // ------------------------------------------------------------------
    // Storage array: intentionally not reset
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_access && !r_rw) begin
            r_mem[r_addr] <= r_wdata;
        end
    end

    assign MDataOut = r_rdata;
    assign MRdy     = (r_state == S_DONE);
    assign MBusy    = (r_state != S_IDLE);

endmodule
`default_nettype wire
